motor_drive_controller: RTL and testbench

- Consumes the 4-bit DIR steering command from the line-sensor direction controller and drives the left and right motor H-bridge enables.
- Decodes the command into per-wheel target duty cycles and ramps each wheel's duty toward its target (soft start and soft slow-down).
- Generates the two PWM outputs and forces an immediate brake on a stop or invalid command.
- Sits between the direction controller and the motor driver pins in the top-level design.

---
 rtl/motor_drive_controller.sv | 164 ++++++++++++++++
 tb/tb_motor_drive_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/motor_drive_controller.sv
// Motor drive controller: turns the 4-bit steering command into ramped
// per-wheel duty cycles, drives the two H-bridge enable PWMs, and brakes
// immediately on a stop or undefined command.
module motor_drive_controller #(
  parameter int PWM_W     = 8,
  parameter int PWM_DIV   = 4,
  parameter int FULL_DUTY = 256,
  parameter int VEER_DUTY = 96,
  parameter int RAMP_DIV  = 50000,
  parameter int RAMP_STEP = 4,
  parameter int STOP_HOLD = 1250000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     dir,
  output logic           pwm_l,
  output logic           pwm_r,
  output logic           brake,
  output logic [PWM_W:0] duty_l,
  output logic [PWM_W:0] duty_r,
  output logic           cmd_fault
);

  localparam int DW     = PWM_W + 1;
  localparam int DIV_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int HOLD_W = (STOP_HOLD > 0) ? $clog2(STOP_HOLD + 1) : 1;

  localparam logic [DW-1:0]     FULL     = DW'(FULL_DUTY);
  localparam logic [DW-1:0]     VEER     = DW'(VEER_DUTY);
  localparam logic [DW-1:0]     STEP     = DW'(RAMP_STEP);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STOP_HOLD);
  localparam logic [RAMP_W-1:0] RAMP_END = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_END  = DIV_W'(PWM_DIV - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cmd_q;
  logic              r_fault;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [PWM_W-1:0]  r_pwm_cnt;
  logic [DW-1:0]     r_duty_l, r_duty_r, w_duty_l_nxt, w_duty_r_nxt;
  logic              r_brake, w_brake_nxt;
  logic              r_pwm_l, r_pwm_r;
  logic              w_ramp_tick, w_move, w_bad;
  logic [DW-1:0]     w_tgt_l, w_tgt_r;

  // Move one duty toward its target by at most STEP, never overshooting.
  function automatic logic [DW-1:0] f_ramp(input logic [DW-1:0] cur,
                                           input logic [DW-1:0] tgt);
    logic [DW-1:0] res;
    res = tgt;
    if (cur < tgt) begin
      if ((tgt - cur) > STEP) res = cur + STEP;
    end else if (cur > tgt) begin
      if ((cur - tgt) > STEP) res = cur - STEP;
    end
    return res;
  endfunction

  assign w_ramp_tick = (r_ramp_cnt == RAMP_END);

  // Decode the registered command into wheel targets and validity.
  always_comb begin
    w_move  = 1'b0;
    w_bad   = 1'b0;
    w_tgt_l = '0;
    w_tgt_r = '0;
    case (r_cmd_q)
      4'b0000: begin w_move = 1'b1; w_tgt_l = FULL; w_tgt_r = FULL; end
      4'b0101: begin w_move = 1'b1; w_tgt_l = VEER; w_tgt_r = FULL; end
      4'b1001: begin w_move = 1'b1; w_tgt_l = FULL; w_tgt_r = VEER; end
      4'b1111: ;
      default: w_bad = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_STOP;
    else     r_state <= w_state_nxt;
  end

  // Next state, brake, hold counter and duty ramp.
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cnt;
    w_brake_nxt  = r_brake;
    w_duty_l_nxt = r_duty_l;
    w_duty_r_nxt = r_duty_r;
    case (r_state)
      ST_STOP: begin
        w_brake_nxt  = 1'b1;
        w_duty_l_nxt = '0;
        w_duty_r_nxt = '0;
        if (r_hold_cnt != HOLD_MAX) w_hold_nxt = r_hold_cnt + 1'b1;
        if ((r_hold_cnt == HOLD_MAX) && w_move) begin
          w_state_nxt = ST_RUN;
          w_brake_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_brake_nxt = 1'b0;
        if (!w_move) begin
          // Stop wins over any coincident ramp tick: no ramp-down.
          w_state_nxt  = ST_STOP;
          w_brake_nxt  = 1'b1;
          w_duty_l_nxt = '0;
          w_duty_r_nxt = '0;
          w_hold_nxt   = '0;
        end else if (w_ramp_tick) begin
          w_duty_l_nxt = f_ramp(r_duty_l, w_tgt_l);
          w_duty_r_nxt = f_ramp(r_duty_r, w_tgt_r);
        end
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  // Command capture, fault flag, counters, duties and PWM outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_q    <= 4'b1111;
      r_fault    <= 1'b0;
      r_hold_cnt <= '0;
      r_ramp_cnt <= '0;
      r_div_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_duty_l   <= '0;
      r_duty_r   <= '0;
      r_brake    <= 1'b1;
      r_pwm_l    <= 1'b0;
      r_pwm_r    <= 1'b0;
    end else begin
      r_cmd_q    <= dir;
      if (w_bad) r_fault <= 1'b1;
      r_hold_cnt <= w_hold_nxt;
      r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
      if (r_div_cnt == DIV_END) begin
        r_div_cnt <= '0;
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      r_duty_l   <= w_duty_l_nxt;
      r_duty_r   <= w_duty_r_nxt;
      r_brake    <= w_brake_nxt;
      // Compare against the next duty so a stop also silences PWM on the same edge.
      r_pwm_l    <= !w_brake_nxt && ({1'b0, r_pwm_cnt} < w_duty_l_nxt);
      r_pwm_r    <= !w_brake_nxt && ({1'b0, r_pwm_cnt} < w_duty_r_nxt);
    end
  end

  assign pwm_l     = r_pwm_l;
  assign pwm_r     = r_pwm_r;
  assign brake     = r_brake;
  assign duty_l    = r_duty_l;
  assign duty_r    = r_duty_r;
  assign cmd_fault = r_fault;

endmodule

// File: tb/tb_motor_drive_controller.sv
// Directed bench for motor_drive_controller with small parameters so the
// hold, ramp and PWM behaviour fit in a few hundred cycles. A second
// instance with VEER_DUTY=5 exercises ramp clamping in both directions.
module tb_motor_drive_controller;
  localparam int PW = 4;

  logic          clk, rst;
  logic [3:0]    dir;
  logic          pwm_l, pwm_r, brake, cmd_fault;
  logic [PW:0]   duty_l, duty_r;
  logic          pwm5_l, pwm5_r, brake5, fault5;
  logic [PW:0]   duty5_l, duty5_r;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_l, cnt_r, cnt5_l;

  motor_drive_controller #(
    .PWM_W(4), .PWM_DIV(1), .FULL_DUTY(16), .VEER_DUTY(6),
    .RAMP_DIV(4), .RAMP_STEP(2), .STOP_HOLD(10)
  ) u_dut (
    .clk(clk), .rst(rst), .dir(dir),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .brake(brake),
    .duty_l(duty_l), .duty_r(duty_r), .cmd_fault(cmd_fault)
  );

  motor_drive_controller #(
    .PWM_W(4), .PWM_DIV(1), .FULL_DUTY(16), .VEER_DUTY(5),
    .RAMP_DIV(4), .RAMP_STEP(2), .STOP_HOLD(10)
  ) u_dut5 (
    .clk(clk), .rst(rst), .dir(dir),
    .pwm_l(pwm5_l), .pwm_r(pwm5_r), .brake(brake5),
    .duty_l(duty5_l), .duty_r(duty5_r), .cmd_fault(fault5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_duty(input string tag, input logic [31:0] l, input logic [31:0] r);
    check({tag, "_duty_l"}, 32'(duty_l), l);
    check({tag, "_duty_r"}, 32'(duty_r), r);
  endtask

  task automatic check_stopped(input string tag);
    check({tag, "_brake"}, 32'(brake), 32'd1);
    check_duty(tag, 32'd0, 32'd0);
    check({tag, "_pwm"}, 32'({pwm_l, pwm_r}), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    dir = 4'b0000;
    #2 rst = 1'b1;
    step(2);
    check_stopped("reset");
    check("reset_fault", 32'(cmd_fault), 32'd0);
    rst = 1'b0;

    // Edge numbers below count posedges since reset release.
    step(10);                                   // E10: hold not yet done
    check_stopped("hold_e10");
    step(1);                                    // E11: RUN entered
    check("run_e11_brake", 32'(brake), 32'd0);
    check_duty("run_e11", 32'd0, 32'd0);
    step(1);                                    // E12: first ramp tick
    check_duty("ramp_e12", 32'd2, 32'd2);
    step(3);                                    // E15
    check_duty("ramp_e15", 32'd2, 32'd2);
    step(1);                                    // E16
    check_duty("ramp_e16", 32'd4, 32'd4);
    for (int k = 3; k <= 8; k++) begin           // E20..E40
      step(4);
      check_duty("ramp_up", 32'(2 * k), 32'(2 * k));
    end
    check("full5_l", 32'(duty5_l), 32'd16);
    for (int i = 0; i < 16; i++) begin           // E41..E56
      step(1);
      check("full_pwm", 32'({pwm_l, pwm_r}), 32'd3);
    end

    dir = 4'b0101;                              // veer left
    step(4);                                    // E60
    check_duty("veerl_e60", 32'd14, 32'd16);
    for (int k = 2; k <= 5; k++) begin           // E64..E76
      step(4);
      check_duty("veerl", 32'(16 - 2 * k), 32'd16);
    end
    check("veerl5_e76", 32'(duty5_l), 32'd6);
    step(4);                                    // E80
    check_duty("veerl_hold", 32'd6, 32'd16);
    check("veerl5_clamp", 32'(duty5_l), 32'd5);
    cnt_l = 0; cnt_r = 0; cnt5_l = 0;
    for (int i = 0; i < 16; i++) begin           // E81..E96
      step(1);
      cnt_l  += int'(pwm_l);
      cnt_r  += int'(pwm_r);
      cnt5_l += int'(pwm5_l);
    end
    check("pwm_l_highs", 32'(cnt_l), 32'd6);
    check("pwm_r_highs", 32'(cnt_r), 32'd16);
    check("pwm5_l_highs", 32'(cnt5_l), 32'd5);

    dir = 4'b1001;                              // veer right
    for (int k = 1; k <= 5; k++) begin           // E100..E116
      step(4);
      check_duty("veerr", 32'(6 + 2 * k), 32'(16 - 2 * k));
    end
    check("veerr5_l", 32'(duty5_l), 32'd15);
    check("veerr5_r", 32'(duty5_r), 32'd6);

    dir = 4'b0000;
    step(4);                                    // E120
    check_duty("fwd_e120", 32'd16, 32'd8);
    check("fwd5_clamp_l", 32'(duty5_l), 32'd16);
    check("fwd5_r", 32'(duty5_r), 32'd8);
    step(16);                                   // E136
    check_duty("fwd_e136", 32'd16, 32'd16);

    dir = 4'b1111;                              // stop
    step(1);                                    // E137: not yet
    check("stop_e137_brake", 32'(brake), 32'd0);
    check("stop_e137_duty", 32'(duty_l), 32'd16);
    step(1);                                    // E138: stopped
    check_stopped("stop_e138");
    check("stop5_brake", 32'(brake5), 32'd1);
    step(3);                                    // E141
    dir = 4'b0000;
    step(7);                                    // E148
    check_stopped("rehold_e148");
    step(1);                                    // E149
    check("rerun_e149", 32'(brake), 32'd0);
    step(3);                                    // E152
    check_duty("rerun_e152", 32'd2, 32'd2);
    step(28);                                   // E180
    check_duty("rerun_e180", 32'd16, 32'd16);

    dir = 4'b0110;                              // undefined code
    step(1);                                    // E181
    check("bad_e181_fault", 32'(cmd_fault), 32'd0);
    check("bad_e181_brake", 32'(brake), 32'd0);
    step(1);                                    // E182
    check_stopped("bad_e182");
    check("bad_e182_fault", 32'(cmd_fault), 32'd1);
    dir = 4'b0000;
    step(11);                                   // E193
    check("bad_rerun_brake", 32'(brake), 32'd0);
    check("bad_sticky_fault", 32'(cmd_fault), 32'd1);
    step(15);                                   // E208
    check_duty("mid_e208", 32'd8, 32'd8);

    #2 rst = 1'b1;                              // async reset mid-ramp
    #1;
    check_stopped("async_rst");
    check("async_rst_fault", 32'(cmd_fault), 32'd0);
    step(1);
    check_stopped("rst_held");
    rst = 1'b0;
    step(10);
    check_stopped("post_rst_e10");
    step(1);
    check("post_rst_e11", 32'(brake), 32'd0);
    step(1);
    check_duty("post_rst_e12", 32'd2, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
